// File: rtl/serial_tx_uart.sv
// serial_tx_uart
//   Takes bytes from the processor serial port, buffers them in a circular
//   FIFO and sends them as 8N1 UART frames, LSB first, at CLKS_PER_BIT clocks
//   per bit. When the FIFO still holds data at the end of a stop bit, the next
//   frame follows without an idle gap.
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous active-high reset, clears all state
//   data_in[7:0]  byte to push (processor serial_out)
//   wren_in       push strobe, one byte per cycle
//   ready_out     FIFO not full (processor serial_ready_in)
//   tx_out        UART TX line, idle high
//   busy_out      FIFO non-empty or a frame in progress
//   overflow_out  sticky flag: a push was dropped because the FIFO was full

module serial_tx_uart #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       wren_in,
    output logic       ready_out,
    output logic       tx_out,
    output logic       busy_out,
    output logic       overflow_out
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push_c;
    logic             pop_c;
    logic             full_c;
    logic             not_empty_c;

    // Transmit state
    state_t            state;
    state_t            state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [7:0]        shifter;
    logic [7:0]        shifter_next;
    logic              tx_next;
    logic              baud_done_c;

    assign full_c      = (count == CNT_FULL);
    assign not_empty_c = (count != '0);
    assign push_c      = wren_in && !full_c;
    assign baud_done_c = (baud_cnt == BAUD_LAST);

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        count_next = count;
        case ({push_c, pop_c})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO data array; contents need no reset because count guards every read.
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers, occupancy and the flags derived from them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ready_out    <= 1'b1;
            overflow_out <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_next;
            ready_out <= (count_next != CNT_FULL);
            // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
            if (wren_in && full_c) begin
                overflow_out <= 1'b1;
            end
        end
    end

    // Transmit FSM state and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
            tx_out   <= 1'b1;
            busy_out <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shifter  <= shifter_next;
            tx_out   <= tx_next;
            busy_out <= (state_next != S_IDLE) || (count_next != '0);
        end
    end

    // Next-state, pop request and next line level.
    always_comb begin
        state_next   = state;
        baud_next    = baud_cnt;
        bit_next     = bit_idx;
        shifter_next = shifter;
        pop_c        = 1'b0;
        tx_next      = 1'b1;

        case (state)
            S_IDLE: begin
                if (not_empty_c) begin
                    pop_c        = 1'b1;
                    shifter_next = mem[rd_ptr];
                    baud_next    = '0;
                    state_next   = S_START;
                end
            end
            S_START: begin
                if (baud_done_c) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = S_DATA;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_done_c) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        shifter_next = {1'b0, shifter[7:1]};
                        bit_next     = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_done_c) begin
                    baud_next = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (not_empty_c) begin
                        pop_c        = 1'b1;
                        shifter_next = mem[rd_ptr];
                        state_next   = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // The line level is a function of where the FSM will be after this edge.
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shifter_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_tx_uart.sv
// tb_serial_tx_uart
//   Two instances: u_dut4 (CLKS_PER_BIT=4) for the directed scenarios and
//   u_dut2 (CLKS_PER_BIT=2) for the long random stream. A line monitor decodes
//   frames from each TX pin; expected bytes come from queues of what was pushed.

module tb_serial_tx_uart;

    localparam int unsigned CPB_A  = 4;
    localparam int unsigned CPB_B  = 2;
    localparam int unsigned DEPTH  = 16;
    localparam int          N_RAND = 2000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data4 = 8'h00;
    logic       wren4 = 1'b0;
    logic [7:0] data2 = 8'h00;
    logic       wren2 = 1'b0;
    logic       ready4, tx4, busy4, ovf4;
    logic       ready2, tx2, busy2, ovf2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int frame_err = 0;

    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];
    int         start0[$];

    serial_tx_uart #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH)) u_dut4 (
        .clock(clock), .reset(reset), .data_in(data4), .wren_in(wren4),
        .ready_out(ready4), .tx_out(tx4), .busy_out(busy4), .overflow_out(ovf4)
    );

    serial_tx_uart #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) u_dut2 (
        .clock(clock), .reset(reset), .data_in(data2), .wren_in(wren2),
        .ready_out(ready2), .tx_out(tx2), .busy_out(busy2), .overflow_out(ovf2)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    // UART receive monitor: samples mid-bit on the falling clock edge.
    initial begin
        bit         mon_on [2];
        int         mon_t  [2];
        logic [7:0] mon_b  [2];
        logic       line;
        int         c;
        mon_on = '{0, 0};
        mon_t  = '{0, 0};
        mon_b  = '{8'h00, 8'h00};
        forever begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                line = (d == 0) ? tx4 : tx2;
                c    = (d == 0) ? CPB_A : CPB_B;
                if (reset) begin
                    mon_on[d] = 0;
                end else if (!mon_on[d]) begin
                    if (line == 1'b0) begin
                        mon_on[d] = 1;
                        mon_t[d]  = 0;
                        if (d == 0) start0.push_back(cyc);
                    end
                end else begin
                    mon_t[d] = mon_t[d] + 1;
                    if (mon_t[d] == c / 2 && line !== 1'b0) frame_err = frame_err + 1;
                    for (int k = 0; k < 8; k++) begin
                        if (mon_t[d] == c * (1 + k) + c / 2) mon_b[d][k] = line;
                    end
                    if (mon_t[d] == c * 9 + c / 2) begin
                        if (line !== 1'b1) frame_err = frame_err + 1;
                        if (d == 0) rxq0.push_back(mon_b[d]);
                        else        rxq1.push_back(mon_b[d]);
                        mon_on[d] = 0;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        int bad4, bad2;
        reset = 1'b1;
        step(2);
        checks++;
        if ({tx4, ready4, busy4, ovf4} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_dut4 got %b want 1100", {tx4, ready4, busy4, ovf4});
        end
        checks++;
        if ({tx2, ready2, busy2, ovf2} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_dut2 got %b want 1100", {tx2, ready2, busy2, ovf2});
        end
        reset = 1'b0;
        bad4 = 0;
        bad2 = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if ({tx4, ready4, busy4, ovf4} !== 4'b1100) bad4++;
            if ({tx2, ready2, busy2, ovf2} !== 4'b1100) bad2++;
        end
        checks++;
        if (bad4 !== 0) begin
            errors++;
            $display("FAIL idle_100_dut4 got %0d bad cycles want 0", bad4);
        end
        checks++;
        if (bad2 !== 0) begin
            errors++;
            $display("FAIL idle_100_dut2 got %0d bad cycles want 0", bad2);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        logic [9:0] frame;
        int         bad_tx, bad_busy;
        b = 8'h48;
        frame = {1'b1, b, 1'b0};
        rxq0.delete();
        data4 = b;
        wren4 = 1'b1;
        step(1);
        wren4 = 1'b0;
        checks++;
        if ({tx4, busy4} !== 2'b11) begin
            errors++;
            $display("FAIL single_after_push got tx,busy=%b want 11", {tx4, busy4});
        end
        bad_tx = 0;
        bad_busy = 0;
        for (int c = 0; c < 10 * CPB_A; c++) begin
            step(1);
            if (tx4 !== frame[c / CPB_A]) bad_tx++;
            if (busy4 !== 1'b1) bad_busy++;
        end
        checks++;
        if (bad_tx !== 0) begin
            errors++;
            $display("FAIL single_waveform got %0d wrong tx cycles want 0", bad_tx);
        end
        checks++;
        if (bad_busy !== 0) begin
            errors++;
            $display("FAIL single_busy_in_frame got %0d low cycles want 0", bad_busy);
        end
        step(1);
        checks++;
        if ({tx4, busy4} !== 2'b10) begin
            errors++;
            $display("FAIL single_after_stop got tx,busy=%b want 10", {tx4, busy4});
        end
        checks++;
        if (rxq0.size() !== 1 || rxq0[0] !== b) begin
            errors++;
            $display("FAIL single_decode got %0d bytes first %h want 1 byte %h",
                     rxq0.size(), (rxq0.size() > 0) ? rxq0[0] : 8'hxx, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        exp = '{8'h55, 8'hAA};
        rxq0.delete();
        start0.delete();
        data4 = exp[0];
        wren4 = 1'b1;
        step(1);
        data4 = exp[1];
        step(1);
        wren4 = 1'b0;
        step(100);
        checks++;
        if (rxq0.size() !== exp.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", rxq0.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (rxq0[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d got %h want %h", i, rxq0[i], exp[i]);
                end
            end
        end
        checks++;
        if (start0.size() !== 2 || (start0[1] - start0[0]) !== 10 * CPB_A) begin
            errors++;
            $display("FAIL b2b_gapless got %0d starts spacing %0d want 2 spacing %0d",
                     start0.size(), (start0.size() > 1) ? start0[1] - start0[0] : -1, 10 * CPB_A);
        end
    endtask

    task automatic test_overflow();
        int  bad_ready, bad_ovf, guard;
        logic exp_ready, exp_ovf;
        rxq0.delete();
        bad_ready = 0;
        bad_ovf = 0;
        for (int k = 1; k <= 18; k++) begin
            data4 = 8'(k - 1);
            wren4 = 1'b1;
            step(1);
            // First byte leaves the FIFO one edge after it arrives, so it holds k-1 after push k>1.
            exp_ready = (k < 17);
            exp_ovf   = (k >= 18);
            if (ready4 !== exp_ready) bad_ready++;
            if (ovf4 !== exp_ovf) bad_ovf++;
        end
        wren4 = 1'b0;
        checks++;
        if (bad_ready !== 0) begin
            errors++;
            $display("FAIL ovf_ready_profile got %0d wrong cycles want 0", bad_ready);
        end
        checks++;
        if (bad_ovf !== 0) begin
            errors++;
            $display("FAIL ovf_flag_profile got %0d wrong cycles want 0", bad_ovf);
        end
        guard = 0;
        while (rxq0.size() < 17 && guard < 17 * 10 * CPB_A + 200) begin
            step(1);
            guard++;
        end
        step(60);
        checks++;
        if (rxq0.size() !== 17) begin
            errors++;
            $display("FAIL ovf_byte_count got %0d want 17", rxq0.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (rxq0[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL ovf_byte%0d got %h want %h", i, rxq0[i], 8'(i));
                end
            end
        end
        checks++;
        if ({ovf4, ready4, busy4} !== 3'b110) begin
            errors++;
            $display("FAIL ovf_sticky got ovf,ready,busy=%b want 110", {ovf4, ready4, busy4});
        end
    endtask

    task automatic test_reset_mid_frame();
        int low_cnt;
        rxq0.delete();
        data4 = 8'h00;
        wren4 = 1'b1;
        step(4);
        wren4 = 1'b0;
        step(8);
        checks++;
        if ({tx4, busy4} !== 2'b01) begin
            errors++;
            $display("FAIL midframe_before_reset got tx,busy=%b want 01", {tx4, busy4});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({tx4, ready4, busy4, ovf4} !== 4'b1100) begin
            errors++;
            $display("FAIL midframe_async_reset got %b want 1100", {tx4, ready4, busy4, ovf4});
        end
        step(2);
        reset = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (tx4 !== 1'b1 || busy4 !== 1'b0) low_cnt++;
        end
        checks++;
        if (low_cnt !== 0 || rxq0.size() !== 0) begin
            errors++;
            $display("FAIL midframe_no_resume got %0d active cycles %0d bytes want 0 0",
                     low_cnt, rxq0.size());
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp[$];
        int sent, iter, guard, fe0;
        fe0 = frame_err;
        rxq1.delete();
        sent = 0;
        iter = 0;
        while (sent < N_RAND && iter < 60000) begin
            if (ready2 === 1'b1 && $urandom_range(0, 3) != 0) begin
                data2 = 8'($urandom);
                wren2 = 1'b1;
                exp.push_back(data2);
                sent++;
            end else begin
                wren2 = 1'b0;
            end
            step(1);
            iter++;
        end
        wren2 = 1'b0;
        checks++;
        if (sent !== N_RAND) begin
            errors++;
            $display("FAIL rand_push_budget got %0d pushes want %0d", sent, N_RAND);
        end
        guard = 0;
        while (rxq1.size() < exp.size() && guard < (DEPTH + 2) * 10 * CPB_B + 100) begin
            step(1);
            guard++;
        end
        step(30);
        checks++;
        if (rxq1.size() !== exp.size()) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d", rxq1.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (rxq1[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rand_byte%0d got %h want %h", i, rxq1[i], exp[i]);
                end
            end
        end
        checks++;
        if (ovf2 !== 1'b0) begin
            errors++;
            $display("FAIL rand_overflow got %b want 0", ovf2);
        end
        checks++;
        if (frame_err !== fe0) begin
            errors++;
            $display("FAIL rand_framing got %0d errors want %0d", frame_err, fe0);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_random_stream();
        checks++;
        if (frame_err !== 0) begin
            errors++;
            $display("FAIL framing_total got %0d want 0", frame_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
